// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch port and a
// data-memory port. Data normally wins, but a waiting fetch is guaranteed a
// grant after STARVE_MAX consecutive data grants. A stuck memory is bounded
// by a per-grant timeout that returns a NOP and raises a sticky error flag.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int            CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] GNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [2:0]    STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [31:0]   NOP_INSN   = 32'h0000_0013;

    state_t        state_q, state_d;
    logic [2:0]    starve_cnt_q, starve_cnt_d;
    logic [CW-1:0] gnt_cnt_q, gnt_cnt_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          ack_sel_q, ack_sel_d;

    // Arbitration, request capture, completion/timeout handling and starvation tracking.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        gnt_cnt_d    = gnt_cnt_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        ack_sel_d    = ack_sel_q;

        case (state_q)
            IDLE: begin
                if (dm_req && !(if_req && (starve_cnt_q == STARVE_LIM))) begin
                    state_d   = GNT_DM;
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    we_d      = dm_we;
                    gnt_cnt_d = '0;
                    if (if_req && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 3'd1;
                    end
                end else if (if_req) begin
                    state_d      = GNT_IF;
                    addr_d       = if_addr;
                    wdata_d      = '0;
                    we_d         = 1'b0;
                    gnt_cnt_d    = '0;
                    starve_cnt_d = '0;
                end
            end
            GNT_IF, GNT_DM: begin
                if (mem_ready) begin
                    if (state_q == GNT_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = mem_rdata;
                    end
                    ack_sel_d = (state_q == GNT_DM);
                    state_d   = ACK;
                end else if (gnt_cnt_q == GNT_LAST) begin
                    if (state_q == GNT_IF) begin
                        if_rdata_d = NOP_INSN;
                    end else begin
                        dm_rdata_d = NOP_INSN;
                    end
                    ack_sel_d = (state_q == GNT_DM);
                    err_d     = 1'b1;
                    state_d   = ACK;
                end else begin
                    gnt_cnt_d = gnt_cnt_q + CW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!if_req) begin
            starve_cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            gnt_cnt_q    <= '0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            ack_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            gnt_cnt_q    <= gnt_cnt_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            ack_sel_q    <= ack_sel_d;
        end
    end

    assign mem_en    = (state_q == GNT_IF) || (state_q == GNT_DM);
    assign mem_we    = (state_q == GNT_DM) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == ACK) && !ack_sel_q;
    assign dm_ack    = (state_q == ACK) && ack_sel_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = dm_req && !dm_ack;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a per-cycle vector table for the
// basic fetch / simultaneous-request flows, then hand-written sequences for
// starvation, timeout, reset mid-grant and input changes mid-grant.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int checkCount = 0;
    int errCount   = 0;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_rdata;
        logic        mem_ready;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_ack;
        logic        e_dm_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
        logic        e_stall_if;
        logic        e_stall_mem;
        logic        e_err;
    } vec_t;

    vec_t vecs[13];

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Global watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checkCount++;
        errCount++;
        $display("[TB] FAIL %s: expected event did not occur within its cycle budget", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        dm_req    = v.dm_req;
        dm_we     = v.dm_we;
        dm_addr   = v.dm_addr;
        dm_wdata  = v.dm_wdata;
        mem_rdata = v.mem_rdata;
        mem_ready = v.mem_ready;
        @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("row%0d mem_en", idx),    {31'b0, mem_en},    {31'b0, v.e_mem_en});
        checkVal($sformatf("row%0d mem_we", idx),    {31'b0, mem_we},    {31'b0, v.e_mem_we});
        checkVal($sformatf("row%0d mem_addr", idx),  mem_addr,           v.e_mem_addr);
        checkVal($sformatf("row%0d mem_wdata", idx), mem_wdata,          v.e_mem_wdata);
        checkVal($sformatf("row%0d if_ack", idx),    {31'b0, if_ack},    {31'b0, v.e_if_ack});
        checkVal($sformatf("row%0d dm_ack", idx),    {31'b0, dm_ack},    {31'b0, v.e_dm_ack});
        checkVal($sformatf("row%0d if_rdata", idx),  if_rdata,           v.e_if_rdata);
        checkVal($sformatf("row%0d dm_rdata", idx),  dm_rdata,           v.e_dm_rdata);
        checkVal($sformatf("row%0d stall_if", idx),  {31'b0, stall_if},  {31'b0, v.e_stall_if});
        checkVal($sformatf("row%0d stall_mem", idx), {31'b0, stall_mem}, {31'b0, v.e_stall_mem});
        checkVal($sformatf("row%0d err", idx),       {31'b0, err},       {31'b0, v.e_err});
    endtask

    // Main test sequence.
    initial begin
        int  dmGrants;
        int  grantCycles;
        logic seen;

        // rst if_req if_addr dm_req dm_we dm_addr dm_wdata mem_rdata mem_ready |
        // mem_en mem_we mem_addr mem_wdata if_ack dm_ack if_rdata dm_rdata stall_if stall_mem err
        vecs[0]  = '{'1, '0, '0,        '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, '0,          '0,           '0, '0, '0,           '0,           '0, '0, '0};
        vecs[1]  = '{'0, '1, 32'h40,    '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, '0,          '0,           '0, '0, '0,           '0,           '1, '0, '0};
        vecs[2]  = '{'0, '1, 32'h40,    '0, '0, '0,         '0,           32'h00500093, '1,
                     '1, '0, 32'h40,      '0,           '0, '0, '0,           '0,           '1, '0, '0};
        vecs[3]  = '{'0, '1, 32'h40,    '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, 32'h40,      '0,           '1, '0, 32'h00500093, '0,           '0, '0, '0};
        vecs[4]  = '{'0, '0, '0,        '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, 32'h40,      '0,           '0, '0, 32'h00500093, '0,           '0, '0, '0};
        vecs[5]  = '{'0, '1, 32'h80,    '1, '1, 32'h100,    32'hDEADBEEF, '0,           '0,
                     '0, '0, 32'h40,      '0,           '0, '0, 32'h00500093, '0,           '1, '1, '0};
        vecs[6]  = '{'0, '1, 32'h80,    '1, '1, 32'h100,    32'hDEADBEEF, 32'h12345678, '1,
                     '1, '1, 32'h100,     32'hDEADBEEF, '0, '0, 32'h00500093, '0,           '1, '1, '0};
        vecs[7]  = '{'0, '1, 32'h80,    '1, '1, 32'h100,    32'hDEADBEEF, '0,           '0,
                     '0, '0, 32'h100,     32'hDEADBEEF, '0, '1, 32'h00500093, 32'h12345678, '1, '0, '0};
        vecs[8]  = '{'0, '1, 32'h80,    '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, 32'h100,     32'hDEADBEEF, '0, '0, 32'h00500093, 32'h12345678, '1, '0, '0};
        vecs[9]  = '{'0, '1, 32'h80,    '0, '0, '0,         '0,           32'hCAFE0001, '1,
                     '1, '0, 32'h80,      '0,           '0, '0, 32'h00500093, 32'h12345678, '1, '0, '0};
        vecs[10] = '{'0, '1, 32'h80,    '0, '0, '0,         '0,           32'hBAD0BAD0, '1,
                     '0, '0, 32'h80,      '0,           '1, '0, 32'hCAFE0001, 32'h12345678, '0, '0, '0};
        vecs[11] = '{'0, '0, '0,        '0, '0, '0,         '0,           32'hFFFFFFFF, '1,
                     '0, '0, 32'h80,      '0,           '0, '0, 32'hCAFE0001, 32'h12345678, '0, '0, '0};
        vecs[12] = '{'0, '0, '0,        '0, '0, '0,         '0,           '0,           '0,
                     '0, '0, 32'h80,      '0,           '0, '0, 32'hCAFE0001, 32'h12345678, '0, '0, '0};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
            tick();
        end

        // Starvation: fetch held while data re-requests back to back.
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0;
        dm_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'h0000_0BEE;
        dmGrants = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_addr == 32'h300) begin
                    dmGrants++;
                    checkVal("starve_cnt_during_dm", {29'b0, dut.starve_cnt_q}, dmGrants);
                end else begin
                    seen = 1'b1;
                    checkVal("starve_dm_grant_count", dmGrants, 4);
                    checkVal("starve_if_addr", mem_addr, 32'h200);
                    checkVal("starve_cnt_cleared", {29'b0, dut.starve_cnt_q}, 32'd0);
                end
            end
            if (!seen) tick();
        end
        if (!seen) failNow("starve_if_grant");
        tick();
        @(negedge clk);
        checkVal("starve_if_ack", {31'b0, if_ack}, 32'd1);
        checkVal("starve_if_rdata", if_rdata, 32'h0000_0BEE);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        repeat (2) tick();

        // Timeout: data load with a memory that never answers.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; mem_ready = 1'b0;
        grantCycles = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) begin
                grantCycles++;
                if (grantCycles == 1) checkVal("err_before_timeout", {31'b0, err}, 32'd0);
            end
            if (dm_ack) begin
                seen = 1'b1;
                checkVal("timeout_grant_cycles", grantCycles, 15);
                checkVal("timeout_dm_rdata", dm_rdata, 32'h0000_0013);
                checkVal("timeout_err", {31'b0, err}, 32'd1);
                checkVal("timeout_no_if_ack", {31'b0, if_ack}, 32'd0);
            end else begin
                tick();
            end
        end
        if (!seen) failNow("timeout_dm_ack");
        tick();
        dm_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkVal("err_sticky", {31'b0, err}, 32'd1);
        checkVal("err_idle_mem_en", {31'b0, mem_en}, 32'd0);
        tick();

        // Reset during the second fetch-grant cycle.
        if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b0;
        @(negedge clk);
        checkVal("rst_idle_mem_en", {31'b0, mem_en}, 32'd0);
        tick();
        @(negedge clk);
        checkVal("rst_gnt1_mem_en", {31'b0, mem_en}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkVal("rst_gnt2_mem_addr", mem_addr, 32'h500);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkVal("rst_after_mem_en", {31'b0, mem_en}, 32'd0);
        checkVal("rst_after_if_ack", {31'b0, if_ack}, 32'd0);
        checkVal("rst_after_err", {31'b0, err}, 32'd0);
        checkVal("rst_after_mem_addr", mem_addr, 32'd0);
        tick();
        @(negedge clk);
        checkVal("rst_regrant_mem_en", {31'b0, mem_en}, 32'd1);
        checkVal("rst_regrant_mem_addr", mem_addr, 32'h500);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0099;
        tick();
        @(negedge clk);
        checkVal("rst_regrant_if_ack", {31'b0, if_ack}, 32'd1);
        checkVal("rst_regrant_if_rdata", if_rdata, 32'h0000_0099);
        if_req = 1'b0; mem_ready = 1'b0;
        repeat (2) tick();

        // Requester changes address and drops request mid-grant, 3-cycle memory.
        if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b0;
        tick();
        @(negedge clk);
        checkVal("chg_gnt1_mem_addr", mem_addr, 32'h600);
        if_addr = 32'h7FC;
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checkVal("chg_gnt2_mem_addr", mem_addr, 32'h600);
        checkVal("chg_gnt2_mem_en", {31'b0, mem_en}, 32'd1);
        tick();
        @(negedge clk);
        checkVal("chg_gnt3_mem_addr", mem_addr, 32'h600);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0011;
        tick();
        @(negedge clk);
        checkVal("chg_ack_if_ack", {31'b0, if_ack}, 32'd1);
        checkVal("chg_ack_mem_addr", mem_addr, 32'h600);
        checkVal("chg_ack_mem_en", {31'b0, mem_en}, 32'd0);
        checkVal("chg_ack_if_rdata", if_rdata, 32'h0000_0011);
        mem_ready = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 SHALL provide parameter TIMEOUT, default 15: maximum cycles in a grant state without mem_ready.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports clk and reset; no other clock or async input.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request; held until if_ack
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction; valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data-memory request; held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data; valid with dm_ack
- dm_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  shared single-port memory enable
- mem_we  out  1  shared memory write enable
- mem_addr  out  32  shared memory address
- mem_wdata  out  32  shared memory write data
- mem_rdata  in  32  shared memory read data; valid when mem_ready = 1
- mem_ready  in  1  memory completion; may take 1..n cycles
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze EX/MEM and upstream stages
- err  out  1  sticky timeout flag

Function
REQ-005 SHALL implement the FSM states IDLE, GNT_IF, GNT_DM and ACK.
REQ-006 In IDLE with no request, SHALL stay in IDLE with mem_en = 0.
REQ-007 In IDLE with only if_req, SHALL go to GNT_IF; with only dm_req, SHALL go to GNT_DM.
REQ-008 In IDLE with both requests, SHALL go to GNT_DM unless starve_cnt = STARVE_MAX, in which case it SHALL go to GNT_IF.
REQ-009 starve_cnt (3-bit) SHALL increment, saturating at STARVE_MAX, on each GNT_DM entry while if_req = 1.
REQ-010 starve_cnt SHALL clear on GNT_IF entry or whenever if_req = 0.
REQ-011 Grant state is registered: the request is sampled in cycle N and mem_en = 1 in cycle N+1.
REQ-012 Address, write data and we SHALL be captured into registers on grant entry and held constant on mem_* for the whole grant, regardless of requester input changes.
REQ-013 mem_we SHALL be 0 in GNT_IF and equal the captured dm_we in GNT_DM.
REQ-014 In a grant state with mem_ready = 1, SHALL capture mem_rdata into the granted requester's rdata register, set ack_sel, and go to ACK.
REQ-015 mem_en SHALL deassert in the ACK cycle.
REQ-016 In ACK, SHALL pulse exactly one of if_ack/dm_ack for one cycle, then go to IDLE.
REQ-017 Back-to-back: a request still pending in ACK is re-arbitrated from IDLE on the following cycle. Minimum transaction is 3 cycles with 1-cycle memory.
REQ-018 if_rdata and dm_rdata SHALL hold their last captured value until the next capture.
REQ-019 For a store, dm_rdata SHALL be captured unchanged (don't-care content).
REQ-020 stall_if = if_req & ~if_ack and stall_mem = dm_req & ~dm_ack, both combinational.
REQ-021 A per-grant cycle counter SHALL clear on grant entry.
REQ-022 If the grant-cycle counter reaches TIMEOUT without mem_ready, SHALL set err = 1, pulse the ack of the granted requester with rdata = 32'h0000_0013 (NOP), and go through ACK to IDLE.
REQ-023 err SHALL remain 1 until reset.
REQ-024 A requester dropping its request mid-grant SHALL NOT abort the transaction; its ack still pulses.
REQ-025 mem_ready seen in IDLE or ACK SHALL be ignored.

Reset
REQ-026 On reset = 1 at a clk edge, the state SHALL go to IDLE.
REQ-027 On reset, starve_cnt, the grant-cycle counter and err SHALL clear.
REQ-028 On reset, mem_en, mem_we, if_ack and dm_ack SHALL be 0.
REQ-029 On reset, mem_addr, mem_wdata, if_rdata and dm_rdata SHALL be 0.
REQ-030 Reset mid-grant SHALL abort the transaction with no ack; the requester re-requests.
REQ-031 The first grant is possible in the cycle after reset deasserts.

Verification
REQ-032 Bench SHALL cover single fetch: if_req=1, if_addr=0x40, mem_ready 1 cycle after mem_en, mem_rdata=0x00500093 -> mem_addr=0x40, mem_we=0, if_ack pulses on cycle 3 with if_rdata=0x00500093.
REQ-033 Bench SHALL cover simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> DM granted first with mem_we=1, mem_wdata=0xDEADBEEF; IF granted next; stall_if=1 until its ack.
REQ-034 Bench SHALL cover starvation: IF held high while DM re-requests continuously -> exactly 4 consecutive DM grants, then an IF grant, then starve_cnt=0.
REQ-035 Bench SHALL cover timeout: dm_req load, mem_ready held 0 -> after 15 grant cycles err=1, dm_ack pulses with dm_rdata=0x00000013, and err stays 1 afterward.
REQ-036 Bench SHALL cover reset mid-grant: reset in the 2nd GNT_IF cycle -> no if_ack, mem_en=0 next cycle, and a new grant the cycle after reset deasserts.
REQ-037 Bench SHALL cover input change mid-grant: if_addr changed during GNT_IF with a 3-cycle memory -> mem_addr holds the originally captured value until ACK.
